// File: rtl/fir_decim_fifo.sv
// FIR output stage: drops warm-up samples, decimates by DECIM (pick or block average)
// and queues results in a first-word-fall-through FIFO with overflow accounting.
module fir_decim_fifo #(
  parameter int DECIM  = 4,
  parameter int AVG    = 0,
  parameter int DEPTH  = 16,
  parameter int WARMUP = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [15:0]         y_in,
  input  logic                       in_en,
  output logic signed [15:0]         m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       warm_done,
  input  logic                       clr_ovf,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int LG   = $clog2(DECIM);
  localparam int PW   = (DECIM > 1) ? LG : 1;
  localparam int WCW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int ACCW = 16 + LG;
  localparam logic [PW-1:0]  PH_LAST   = PW'(DECIM - 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [AW:0]    FULL_LVL  = (AW + 1)'(DEPTH);

  logic [WCW-1:0]         warmCnt_q, warmCnt_d;
  logic                   warmDone_q, warmDone_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [AW-1:0]          wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            dropCnt_q, dropCnt_d;
  logic signed [15:0]     mem [DEPTH];

  logic                   accept, lastPhase, pushReq, pop, full, pushOk, drop;
  logic signed [ACCW-1:0] yExt, sum;
  logic signed [15:0]     avgVal, pushVal;

  assign accept    = in_en && warmDone_q;
  assign lastPhase = (phase_q == PH_LAST);
  assign pushReq   = accept && lastPhase;
  assign pop       = m_valid && m_ready;
  assign full      = (count_q == FULL_LVL);
  assign pushOk    = pushReq && (!full || pop);
  assign drop      = pushReq && full && !pop;

  // Phase 0 restarts the block sum, so the accumulator never needs an explicit clear.
  assign yExt    = ACCW'(y_in);
  assign sum     = ((phase_q == '0) ? '0 : acc_q) + yExt;
  assign avgVal  = 16'(sum >>> LG);
  assign pushVal = (AVG != 0) ? avgVal : y_in;

  always_comb begin
    warmCnt_d  = warmCnt_q;
    warmDone_d = warmDone_q;
    if (WARMUP == 0) begin
      warmDone_d = 1'b1;
    end else if (in_en && !warmDone_q) begin
      if (warmCnt_q == WARM_LAST) warmDone_d = 1'b1;
      else warmCnt_d = warmCnt_q + 1'b1;
    end
  end

  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    if (accept) begin
      phase_d = lastPhase ? '0 : phase_q + 1'b1;
      acc_d   = sum;
    end
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    dropCnt_d = dropCnt_q;
    if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
    if (pop) rdPtr_d = rdPtr_q + 1'b1;
    case ({pushOk, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear wins, so no overflow event is ever lost.
    if (drop) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    if (drop && dropCnt_q != 16'hFFFF) dropCnt_d = dropCnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warmCnt_q  <= '0;
      warmDone_q <= 1'b0;
      phase_q    <= '0;
      acc_q      <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      warmCnt_q  <= warmCnt_d;
      warmDone_q <= warmDone_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Storage is not reset; m_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr_q] <= pushVal;
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? mem[rdPtr_q] : '0;
  assign level     = count_q;
  assign warm_done = warmDone_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = dropCnt_q;

endmodule
